// File: rtl/xilinx_primitive_pkg.sv
// Shared definitions for the Xilinx FIFO primitive wrappers and their adapters.
package xilinx_primitive_pkg;

  typedef enum logic {
    FIFO_18KB = 1'b0,
    FIFO_36KB = 1'b1
  } fifo_size_e;

  localparam int READ_LATENCY_MIN = 1;  // DO_REG=0
  localparam int READ_LATENCY_MAX = 2;  // DO_REG=1

  // Word depth of a FIFO18E1/FIFO36E1 for a given data width.
  function automatic int fifo_depth(input int data_width, input fifo_size_e size);
    int d;
    if (data_width <= 4)       d = 4096;
    else if (data_width <= 9)  d = 2048;
    else if (data_width <= 18) d = 1024;
    else if (data_width <= 36) d = 512;
    else                       d = 256;
    if (size == FIFO_36KB) d = d * 2;
    return d;
  endfunction

endpackage

// File: rtl/xilinx_skid_buffer.sv
// Circular buffer with push/pop and occupancy; depth need not be a power of 2.
module xilinx_skid_buffer #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [DATA_WIDTH-1:0]        push_data_i,
  input  logic                         pop_i,
  output logic [DATA_WIDTH-1:0]        rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) wptr_d = ptr_inc(wptr_q);
    if (pop_i)  rptr_d = ptr_inc(rptr_q);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared too so the output reads zero after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (push_i) mem_q[wptr_q] <= push_data_i;
    end
  end

  assign rd_data_o = mem_q[rptr_q];
  assign count_o   = cnt_q;

endmodule

// File: rtl/xilinx_fifo_rd_stream.sv
// Drives a non-FWFT BRAM FIFO read port and re-presents its data as a
// bubble-free valid/ready stream through a small skid buffer.
module xilinx_fifo_rd_stream
  import xilinx_primitive_pkg::*;
#(
  parameter int DATA_WIDTH   = 4,
  parameter int READ_LATENCY = 1,
  parameter int BUF_DEPTH    = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FIFO_EMPTY,
  input  logic                  FIFO_RDERR,
  input  logic [DATA_WIDTH-1:0] FIFO_DO,
  output logic                  FIFO_RDEN,
  output logic                  M_TVALID,
  input  logic                  M_TREADY,
  output logic [DATA_WIDTH-1:0] M_TDATA,
  output logic [CNT_WIDTH-1:0]  WORD_COUNT,
  output logic                  ERR
);
  localparam int BW = $clog2(BUF_DEPTH+1);
  localparam int UW = $clog2(BUF_DEPTH+READ_LATENCY+1);

  generate
    if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX ||
        BUF_DEPTH < READ_LATENCY+1 || BUF_DEPTH > 16) begin : g_bad_cfg
      $error("xilinx_fifo_rd_stream: unsupported READ_LATENCY/BUF_DEPTH");
    end
  endgenerate

  logic [READ_LATENCY-1:0] infl_q, infl_d;
  logic [CNT_WIDTH-1:0]    wcnt_q, wcnt_d;
  logic                    err_q, err_d;
  logic [BW-1:0]           bcnt;
  logic [UW-1:0]           used;
  logic                    pop, capture;

  assign M_TVALID = (bcnt != '0);
  assign pop      = M_TVALID & M_TREADY;
  assign capture  = infl_q[READ_LATENCY-1];

  // Credit: every issued read must have a slot waiting when its data lands.
  assign used      = UW'(bcnt) + UW'($countones(infl_q)) - UW'(pop);
  assign FIFO_RDEN = !FIFO_EMPTY && !RST && (used < UW'(BUF_DEPTH));

  always_comb begin
    infl_d = READ_LATENCY'({infl_q, FIFO_RDEN});
    wcnt_d = wcnt_q + CNT_WIDTH'(pop);
    err_d  = err_q | FIFO_RDERR;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      infl_q <= '0;
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      infl_q <= infl_d;
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
  end

  xilinx_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (capture),
    .push_data_i (FIFO_DO),
    .pop_i       (pop),
    .rd_data_o   (M_TDATA),
    .count_o     (bcnt)
  );

  assign WORD_COUNT = wcnt_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_xilinx_fifo_rd_stream.sv
// Directed bench: two configurations (latency 1 / depth 2, latency 2 / depth 3
// with a 4-bit counter) each fed by a behavioural non-FWFT FIFO.
module tb_xilinx_fifo_rd_stream;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // ---------------- configuration A: latency 1, depth 2 ----------------
  logic       empty_a, rderr_a, rden_a, tvalid_a, tready_a, err_a;
  logic [7:0] do_a, tdata_a;
  logic [31:0] wc_a;
  logic [7:0] mem_a [2048];
  int         wr_a = 0, rd_a = 0, exp_a = 0;
  logic       rdy_man_a = 1'b0, rnd_on_a = 1'b0, rnd_bit_a = 1'b0;

  xilinx_fifo_rd_stream #(.DATA_WIDTH(8), .READ_LATENCY(1), .BUF_DEPTH(2), .CNT_WIDTH(32)) u_dut_a (
    .CLK(CLK), .RST(RST), .FIFO_EMPTY(empty_a), .FIFO_RDERR(rderr_a), .FIFO_DO(do_a),
    .FIFO_RDEN(rden_a), .M_TVALID(tvalid_a), .M_TREADY(tready_a), .M_TDATA(tdata_a),
    .WORD_COUNT(wc_a), .ERR(err_a));

  assign empty_a  = (wr_a == rd_a);
  assign tready_a = rnd_on_a ? rnd_bit_a : rdy_man_a;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_a <= wr_a;
      do_a <= 8'h00;
    end else if (rden_a) begin
      do_a <= mem_a[rd_a[10:0]];
      rd_a <= rd_a + 1;
    end
  end

  always @(posedge CLK) begin
    #1 rnd_bit_a = 1'($urandom_range(0, 1));
  end

  always @(negedge CLK) begin
    if (RST) exp_a = wr_a;
    else begin
      chk("rden_while_empty_a", 32'(rden_a & empty_a), 32'd0);
      if (tvalid_a && tready_a) begin
        chk("beat_a", 32'(tdata_a), 32'(mem_a[exp_a[10:0]]));
        exp_a++;
      end
    end
  end

  task automatic push_a(input logic [7:0] d);
    mem_a[wr_a[10:0]] = d;
    wr_a++;
  endtask

  task automatic drain_a();
    int n = 0;
    while (exp_a != wr_a && n < 4000) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_a", 32'(exp_a == wr_a), 32'd1);
    step(2);
  endtask

  // ---------------- configuration B: latency 2, depth 3, 4-bit count ----------------
  logic       empty_b, rderr_b, rden_b, tvalid_b, tready_b, err_b;
  logic [7:0] do1_b, do2_b, tdata_b;
  logic [3:0] wc_b;
  logic [7:0] mem_b [2048];
  int         wr_b = 0, rd_b = 0, exp_b = 0;

  xilinx_fifo_rd_stream #(.DATA_WIDTH(8), .READ_LATENCY(2), .BUF_DEPTH(3), .CNT_WIDTH(4)) u_dut_b (
    .CLK(CLK), .RST(RST), .FIFO_EMPTY(empty_b), .FIFO_RDERR(rderr_b), .FIFO_DO(do2_b),
    .FIFO_RDEN(rden_b), .M_TVALID(tvalid_b), .M_TREADY(tready_b), .M_TDATA(tdata_b),
    .WORD_COUNT(wc_b), .ERR(err_b));

  assign empty_b = (wr_b == rd_b);

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_b  <= wr_b;
      do1_b <= 8'h00;
      do2_b <= 8'h00;
    end else begin
      if (rden_b) begin
        do1_b <= mem_b[rd_b[10:0]];
        rd_b  <= rd_b + 1;
      end
      do2_b <= do1_b;
    end
  end

  always @(negedge CLK) begin
    if (RST) exp_b = wr_b;
    else begin
      chk("rden_while_empty_b", 32'(rden_b & empty_b), 32'd0);
      if (tvalid_b && tready_b) begin
        chk("beat_b", 32'(tdata_b), 32'(mem_b[exp_b[10:0]]));
        exp_b++;
      end
    end
  end

  task automatic push_b(input logic [7:0] d);
    mem_b[wr_b[10:0]] = d;
    wr_b++;
  endtask

  task automatic drain_b();
    int n = 0;
    while (exp_b != wr_b && n < 4000) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_b", 32'(exp_b == wr_b), 32'd1);
    step(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    int pushed;
    rderr_a  = 1'b0;
    rderr_b  = 1'b0;
    tready_b = 1'b0;
    #1;
    chk("rst_rden_a",   32'(rden_a),   32'd0);
    chk("rst_tvalid_a", 32'(tvalid_a), 32'd0);
    chk("rst_tdata_a",  32'(tdata_a),  32'd0);
    chk("rst_wc_a",     wc_a,          32'd0);
    chk("rst_err_a",    32'(err_a),    32'd0);
    step(2);
    RST = 1'b0;
    step(1);

    // Streaming: 16 words, latency 1 -> first valid 2 cycles later, no bubbles.
    rdy_man_a = 1'b1;
    for (int i = 0; i < 16; i++) push_a(8'(i));
    n = 0;
    @(negedge CLK);
    while (!tvalid_a && n < 20) begin
      n++;
      @(negedge CLK);
    end
    chk("stream_first_valid_a", 32'(n), 32'd2);
    for (int i = 1; i < 16; i++) begin
      @(negedge CLK);
      chk("stream_no_bubble_a", 32'(tvalid_a), 32'd1);
    end
    @(negedge CLK);
    chk("stream_idle_a", 32'(tvalid_a), 32'd0);
    chk("stream_wc_a",   wc_a,          32'd16);
    step(1);

    // Backpressure: 8 words, ready low 10 cycles -> 2 reads, head word held.
    rdy_man_a = 1'b0;
    for (int i = 0; i < 8; i++) push_a(8'(i));
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      pulses += int'(rden_a);
      if (tvalid_a) chk("bp_hold_a", 32'(tdata_a), 32'd0);
    end
    chk("bp_rden_pulses_a", 32'(pulses), 32'd2);
    chk("bp_tvalid_a",      32'(tvalid_a), 32'd1);
    chk("bp_err_a",         32'(err_a),    32'd0);
    step(1);
    rdy_man_a = 1'b1;
    drain_a();
    chk("bp_wc_a", wc_a, 32'd24);

    // Random ready and bursty FIFO fill: 1000 words.
    rnd_on_a = 1'b1;
    pushed = 0;
    while (pushed < 1000) begin
      if ($urandom_range(0, 1) == 1) begin
        push_a(8'($urandom));
        pushed++;
      end
      step(1);
    end
    drain_a();
    rnd_on_a = 1'b0;
    chk("rand_wc_a",  wc_a,       32'd1024);
    chk("rand_err_a", 32'(err_a), 32'd0);

    // Sticky error.
    rderr_a = 1'b1;
    step(1);
    rderr_a = 1'b0;
    chk("err_set_a", 32'(err_a), 32'd1);
    step(5);
    chk("err_sticky_a", 32'(err_a), 32'd1);

    // Asynchronous reset mid-cycle with two words buffered.
    rdy_man_a = 1'b0;
    for (int i = 0; i < 4; i++) push_a(8'(8'h31 + i));
    step(6);
    chk("pre_rst_tvalid_a", 32'(tvalid_a), 32'd1);
    chk("pre_rst_tdata_a",  32'(tdata_a),  32'h31);
    #2;
    RST = 1'b1;
    #1;
    chk("mid_rst_tvalid_a", 32'(tvalid_a), 32'd0);
    chk("mid_rst_rden_a",   32'(rden_a),   32'd0);
    chk("mid_rst_wc_a",     wc_a,          32'd0);
    chk("mid_rst_err_a",    32'(err_a),    32'd0);
    chk("mid_rst_tdata_a",  32'(tdata_a),  32'd0);
    step(1);
    RST = 1'b0;
    step(1);
    push_a(8'hA5);
    rdy_man_a = 1'b1;
    n = 0;
    while (!tvalid_a && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("post_rst_valid_a", 32'(tvalid_a), 32'd1);
    chk("post_rst_data_a",  32'(tdata_a),  32'hA5);
    drain_a();
    chk("post_rst_wc_a", wc_a, 32'd1);

    // Latency 2, depth 3: first valid 3 cycles later, 32 words without bubbles.
    tready_b = 1'b1;
    for (int i = 0; i < 32; i++) push_b(8'(i * 7 + 3));
    n = 0;
    @(negedge CLK);
    while (!tvalid_b && n < 20) begin
      n++;
      @(negedge CLK);
    end
    chk("lat2_first_valid_b", 32'(n), 32'd3);
    for (int i = 1; i < 32; i++) begin
      @(negedge CLK);
      chk("lat2_no_bubble_b", 32'(tvalid_b), 32'd1);
    end
    drain_b();
    chk("lat2_wc_wrap_b", 32'(wc_b),  32'd0);
    chk("lat2_err_b",     32'(err_b), 32'd0);

    // 4-bit counter wrap: 17 pops -> 1.
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    chk("wrap_rst_wc_b", 32'(wc_b), 32'd0);
    step(1);
    for (int i = 0; i < 17; i++) push_b(8'(8'hC0 + i));
    drain_b();
    chk("wrap_wc_b", 32'(wc_b), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
